clock_divider: RTL and testbench



---
 rtl/clock_divider.sv | 29 ++
 tb/tb_clock_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Power-of-two clock divider: a free-running COUNTER_SIZE-bit counter whose MSB is the output clock.
// Output comes straight from a flip-flop so it is glitch-free, with exact 50% duty.
module clock_divider #(
  parameter int unsigned COUNTER_SIZE = 4
) (
  input  logic clk_in,
  input  logic reset_n,
  output logic clk_out
);

  // Power-up value lets the divider run correctly even if reset is never asserted.
  logic [COUNTER_SIZE-1:0] cnt_q = '0;
  logic [COUNTER_SIZE-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + COUNTER_SIZE'(1);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign clk_out = cnt_q[COUNTER_SIZE-1];

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: free-run edge counts, vector table, async reset,
// and randomized reset stimulus against an arithmetic reference model.
module tb_clock_divider;

  logic clk_in = 1'b0;
  logic run_rst_n = 1'b1;
  logic free_rst_n = 1'b1;

  logic f1_out, f2_out, f3_out, f4_out, f5_out, f6_out;
  logic r2_out, r3_out, r4_out;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  clock_divider #(.COUNTER_SIZE(1)) f1 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f1_out));
  clock_divider #(.COUNTER_SIZE(2)) f2 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f2_out));
  clock_divider #(.COUNTER_SIZE(3)) f3 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f3_out));
  clock_divider #(.COUNTER_SIZE(4)) f4 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f4_out));
  clock_divider #(.COUNTER_SIZE(5)) f5 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f5_out));
  clock_divider #(.COUNTER_SIZE(6)) f6 (.clk_in(clk_in), .reset_n(free_rst_n), .clk_out(f6_out));

  clock_divider #(.COUNTER_SIZE(2)) r2 (.clk_in(clk_in), .reset_n(run_rst_n), .clk_out(r2_out));
  clock_divider #(.COUNTER_SIZE(3)) r3 (.clk_in(clk_in), .reset_n(run_rst_n), .clk_out(r3_out));
  clock_divider #(.COUNTER_SIZE(4)) r4 (.clk_in(clk_in), .reset_n(run_rst_n), .clk_out(r4_out));

  int rise1 = 0, rise2 = 0, rise3 = 0, rise4 = 0, rise5 = 0, rise6 = 0;
  always @(posedge f1_out) rise1 <= rise1 + 1;
  always @(posedge f2_out) rise2 <= rise2 + 1;
  always @(posedge f3_out) rise3 <= rise3 + 1;
  always @(posedge f4_out) rise4 <= rise4 + 1;
  always @(posedge f5_out) rise5 <= rise5 + 1;
  always @(posedge f6_out) rise6 <= rise6 + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic rst_n;
    int   exp_cnt2;
    logic exp_out2;
    logic exp_out3;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int m3;
    int m4;
    int edges;
    bit seen;

    // Edges 1..12 count from reset; 13-14 reset held; 15-16 count again from zero.
    vecs[0]  = '{1'b1, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 3, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 2, 1'b1, 1'b0};

    // Reset held for 20 edges while the free-running set counts from power-up.
    run_rst_n = 1'b0;
    #1;
    check("reset_out_r3", int'(r3_out), 0);
    check("reset_out_r4", int'(r4_out), 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in);
      #1;
      check("held_out_r4", int'(r4_out), 0);
      check("held_cnt_r2", int'(r2.cnt_q), 0);
    end

    #(64'd5000 - $time);
    check("free_rise_n1", rise1, 250);
    check("free_rise_n2", rise2, 125);
    check("free_rise_n3", rise3, 63);
    check("free_rise_n4", rise4, 31);
    check("free_rise_n5", rise5, 16);
    check("free_rise_n6", rise6, 8);

    // Vector table: reset changes between edges, outputs sampled just after each edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      run_rst_n = vecs[i].rst_n;
      @(posedge clk_in);
      #1;
      check($sformatf("vec%0d_cnt2", i), int'(r2.cnt_q), vecs[i].exp_cnt2);
      check($sformatf("vec%0d_out2", i), int'(r2_out), int'(vecs[i].exp_out2));
      check($sformatf("vec%0d_out3", i), int'(r3_out), int'(vecs[i].exp_out3));
    end

    // Async reset mid-high on N=4: drop reset 3 units after edge 10.
    @(negedge clk_in);
    run_rst_n = 1'b0;
    @(negedge clk_in);
    run_rst_n = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    check("async_high_before", int'(r4_out), 1);
    #2;
    run_rst_n = 1'b0;
    #1;
    check("async_dropped", int'(r4_out), 0);
    @(negedge clk_in);
    run_rst_n = 1'b1;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk_in);
      #1;
      edges++;
      seen = r4_out;
    end
    check("async_first_rise_edge", seen ? edges : -1, 8);

    // Randomized reset pulses against an arithmetic model of the count.
    @(negedge clk_in);
    run_rst_n = 1'b0;
    m3 = 0;
    m4 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      #($urandom_range(1, 3));
      run_rst_n = ($urandom_range(0, 7) != 0);
      if (!run_rst_n) begin
        m3 = 0;
        m4 = 0;
      end
      #1;
      check("rand_async_r3", int'(r3_out), int'(m3 >= 4));
      check("rand_async_r4", int'(r4_out), int'(m4 >= 8));
      @(posedge clk_in);
      if (run_rst_n) begin
        m3 = (m3 + 1) % 8;
        m4 = (m4 + 1) % 16;
      end
      #1;
      check("rand_edge_r3", int'(r3_out), int'(m3 >= 4));
      check("rand_edge_r4", int'(r4_out), int'(m4 >= 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
